// File: rtl/rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wport_arbiter
//
// Purpose:
//   Shares the single register-file write port between the in-order WB stage
//   and a multi-cycle side unit (multiplier/divider). Side-unit results land
//   in a small FIFO and are written whenever WB leaves the port idle. A
//   starvation counter forces a one-cycle WB hold so buffered results always
//   drain. A pending-register mask tells DE which registers have buffered
//   writes outstanding.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wb_wr_valid       WB requests a write this cycle
//   wb_wregno         WB destination register
//   wb_wdata          WB write data
//   wb_hold           WB write not taken; WB/MEM must hold their contents
//   mc_wr_valid       side unit offers a result
//   mc_wregno         side-unit destination register
//   mc_wdata          side-unit result
//   mc_wr_ready       FIFO can accept (transfer = valid & ready)
//   rf_wr_en          registered register-file write enable
//   rf_wregno         registered register-file write address
//   rf_wdata          registered register-file write data
//   mc_pending_mask   bit r set while any FIFO entry targets register r
//   fifo_count        current FIFO occupancy
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module rf_wport_arbiter #(
   parameter int DBITS        = 32,
   parameter int REGNOBITS    = 5,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wb_wr_valid,
   input  logic [REGNOBITS-1:0]           wb_wregno,
   input  logic [DBITS-1:0]               wb_wdata,
   output logic                           wb_hold,
   input  logic                           mc_wr_valid,
   input  logic [REGNOBITS-1:0]           mc_wregno,
   input  logic [DBITS-1:0]               mc_wdata,
   output logic                           mc_wr_ready,
   output logic                           rf_wr_en,
   output logic [REGNOBITS-1:0]           rf_wregno,
   output logic [DBITS-1:0]               rf_wdata,
   output logic [2**REGNOBITS-1:0]        mc_pending_mask,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int PTRW = $clog2(FIFO_DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam int SCW  = 4;

   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);
   localparam logic [SCW-1:0]  LIMIT_C = SCW'(STARVE_LIMIT);

   // Source of the write issued to the register file next cycle.
   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WB,
      GNT_WB_ZERO,
      GNT_FIFO
   } grant_e;

   // Saturating increment of the starvation counter.
   function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
      return (v >= LIMIT_C) ? v : v + SCW'(1);
   endfunction

   // FIFO storage (data path, not reset: validity comes from the count)
   logic [REGNOBITS-1:0] fifo_regno_q [FIFO_DEPTH];
   logic [DBITS-1:0]     fifo_data_q  [FIFO_DEPTH];

   // Control state
   logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]      count_q, count_d;
   logic [SCW-1:0]       starve_q, starve_d;

   // Registered write port
   logic                 rf_wr_en_q, rf_wr_en_d;
   logic [REGNOBITS-1:0] rf_wregno_q, rf_wregno_d;
   logic [DBITS-1:0]     rf_wdata_q, rf_wdata_d;

   grant_e               grant;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;
   logic [PTRW-1:0]      slot_ofs;

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == DEPTH_C);
   assign mc_wr_ready = !fifo_full;
   assign wb_hold     = (starve_q >= LIMIT_C);

   // Writes to r0 are accepted on the handshake but never buffered.
   assign push = mc_wr_valid && mc_wr_ready && (mc_wregno != '0);

   // Grant priority: forced drain, then WB, then opportunistic drain.
   always_comb begin
      grant = GNT_NONE;
      if (wb_hold && !fifo_empty) begin
         grant = GNT_FIFO;
      end else if (!wb_hold && wb_wr_valid) begin
         grant = (wb_wregno != '0) ? GNT_WB : GNT_WB_ZERO;
      end else if (!fifo_empty) begin
         grant = GNT_FIFO;
      end
   end

   assign pop = (grant == GNT_FIFO);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase

      // An entry pushed this cycle is not yet in the FIFO, so an empty
      // FIFO keeps the counter at zero even while a push is landing.
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else begin
         starve_d = sat_inc(starve_q);
      end
   end

   always_comb begin
      rf_wr_en_d  = 1'b0;
      rf_wregno_d = rf_wregno_q;
      rf_wdata_d  = rf_wdata_q;
      case (grant)
         GNT_WB: begin
            rf_wr_en_d  = 1'b1;
            rf_wregno_d = wb_wregno;
            rf_wdata_d  = wb_wdata;
         end
         GNT_FIFO: begin
            rf_wr_en_d  = 1'b1;
            rf_wregno_d = fifo_regno_q[rd_ptr_q];
            rf_wdata_d  = fifo_data_q[rd_ptr_q];
         end
         default: begin
            rf_wr_en_d  = 1'b0;
         end
      endcase
   end

   // An entry at physical slot i is live when its distance from the read
   // pointer (modulo depth) is below the occupancy.
   always_comb begin
      mc_pending_mask = '0;
      slot_ofs        = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         slot_ofs = PTRW'(i) - rd_ptr_q;
         if (CNTW'(slot_ofs) < count_q) begin
            mc_pending_mask[fifo_regno_q[i]] = 1'b1;
         end
      end
   end

   // ---- stage p0 -> p1: control and write-port registers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         starve_q    <= '0;
         rf_wr_en_q  <= 1'b0;
         rf_wregno_q <= '0;
         rf_wdata_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         rf_wr_en_q  <= rf_wr_en_d;
         rf_wregno_q <= rf_wregno_d;
         rf_wdata_q  <= rf_wdata_d;
      end
   end

   // ---- stage p0 -> p1: FIFO storage ----
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         fifo_regno_q[wr_ptr_q] <= mc_wregno;
         fifo_data_q[wr_ptr_q]  <= mc_wdata;
      end
   end

   assign rf_wr_en   = rf_wr_en_q;
   assign rf_wregno  = rf_wregno_q;
   assign rf_wdata   = rf_wdata_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
`timescale 1ns/1ps

module tb_rf_wport_arbiter;

   localparam int DBITS        = 32;
   localparam int REGNOBITS    = 5;
   localparam int FIFO_DEPTH   = 2;
   localparam int STARVE_LIMIT = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   wb_wr_valid;
   logic [REGNOBITS-1:0]   wb_wregno;
   logic [DBITS-1:0]       wb_wdata;
   logic                   wb_hold;
   logic                   mc_wr_valid;
   logic [REGNOBITS-1:0]   mc_wregno;
   logic [DBITS-1:0]       mc_wdata;
   logic                   mc_wr_ready;
   logic                   rf_wr_en;
   logic [REGNOBITS-1:0]   rf_wregno;
   logic [DBITS-1:0]       rf_wdata;
   logic [31:0]            mc_pending_mask;
   logic [1:0]             fifo_count;

   always #5 clk = ~clk;

   rf_wport_arbiter #(
      .DBITS(DBITS), .REGNOBITS(REGNOBITS),
      .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .wb_wr_valid(wb_wr_valid), .wb_wregno(wb_wregno), .wb_wdata(wb_wdata),
      .wb_hold(wb_hold),
      .mc_wr_valid(mc_wr_valid), .mc_wregno(mc_wregno), .mc_wdata(mc_wdata),
      .mc_wr_ready(mc_wr_ready),
      .rf_wr_en(rf_wr_en), .rf_wregno(rf_wregno), .rf_wdata(rf_wdata),
      .mc_pending_mask(mc_pending_mask), .fifo_count(fifo_count)
   );

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      logic        en;
      logic [4:0]  r;
      logic [31:0] d;
      int          cnt;
      logic [31:0] mask;
   } exp_t;

   // Reference model state
   ent_t        mq[$];
   exp_t        sb[$];
   int          m_starve = 0;
   logic [4:0]  m_rfr = '0;
   logic [31:0] m_rfd = '0;
   bit          m_known = 0;
   bit          m_last_hold = 0;
   bit          m_last_push = 0;

   int n_tests = 0;
   int n_fail  = 0;
   int dut_holds = 0;

   logic [4:0]  fr [3] = '{5'd3, 5'd4, 5'd6};
   logic [31:0] fd [3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict, push expectation, then compare
   // the registered outputs after the edge.
   task automatic cycle(input bit rst, input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                        input bit mv, input logic [4:0] mr, input logic [31:0] md);
      exp_t e;
      exp_t g;
      ent_t h;
      ent_t n;
      bit   hold;
      bit   ready;
      bit   pop;
      int   pre;
      reset       = rst;
      wb_wr_valid = wv;
      wb_wregno   = wr;
      wb_wdata    = wd;
      mc_wr_valid = mv;
      mc_wregno   = mr;
      mc_wdata    = md;
      hold  = (m_starve >= STARVE_LIMIT);
      ready = (mq.size() != FIFO_DEPTH);
      if (m_known) begin
         check_val("wb_hold", 64'(wb_hold), 64'(hold));
         check_val("mc_wr_ready", 64'(mc_wr_ready), 64'(ready));
      end
      if (wb_hold === 1'b1) dut_holds++;
      m_last_hold = hold;
      m_last_push = 0;
      e.en = 1'b0;
      if (rst) begin
         mq.delete();
         m_starve = 0;
         m_rfr = '0;
         m_rfd = '0;
      end else begin
         pre = mq.size();
         pop = 0;
         if (hold && pre > 0) pop = 1;
         else if (!hold && wv) begin
            if (wr != 0) begin
               e.en = 1'b1;
               m_rfr = wr;
               m_rfd = wd;
            end
         end else if (pre > 0) pop = 1;
         if (pop) begin
            h = mq.pop_front();
            e.en = 1'b1;
            m_rfr = h.r;
            m_rfd = h.d;
         end
         if (pop || pre == 0) m_starve = 0;
         else if (m_starve < STARVE_LIMIT) m_starve++;
         if (mv && ready) begin
            m_last_push = 1;
            if (mr != 0) begin
               n.r = mr;
               n.d = md;
               mq.push_back(n);
            end
         end
      end
      e.r = m_rfr;
      e.d = m_rfd;
      e.cnt = mq.size();
      e.mask = '0;
      foreach (mq[i]) e.mask[mq[i].r] = 1'b1;
      sb.push_back(e);

      @(posedge clk);
      #1;
      g = sb.pop_front();
      check_val("rf_wr_en", 64'(rf_wr_en), 64'(g.en));
      check_val("rf_wregno", 64'(rf_wregno), 64'(g.r));
      check_val("rf_wdata", 64'(rf_wdata), 64'(g.d));
      check_val("fifo_count", 64'(fifo_count), 64'(g.cnt));
      check_val("mc_pending_mask", 64'(mc_pending_mask), 64'(g.mask));
      m_known = 1;
   endtask

   task automatic idle();
      cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int s;
      bit mv;
      reset = 1'b1;
      wb_wr_valid = 0; wb_wregno = '0; wb_wdata = '0;
      mc_wr_valid = 0; mc_wregno = '0; mc_wdata = '0;

      // Power-on reset
      cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      idle();

      // WB-only traffic, then a WB write to r0
      cycle(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
      cycle(0, 1, 5'd0, 32'h1234_5678, 0, 5'd0, 32'd0);
      idle();

      // Idle-port drain, with a push landing while the head pops
      cycle(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h11);
      check_val("drain_mask7_set", 64'(mc_pending_mask[7]), 64'd1);
      cycle(0, 0, 5'd0, 32'd0, 1, 5'd8, 32'h44);
      check_val("drain_write_reg7", 64'(rf_wregno), 64'd7);
      check_val("drain_mask7_clear", 64'(mc_pending_mask[7]), 64'd0);
      idle();
      idle();

      // Starvation: WB writes every cycle, one side-unit result pending
      k = 0;
      dut_holds = 0;
      for (int c = 0; c < 10; c++) begin
         cycle(0, 1, 5'(10 + (k % 5)), 32'hA000_0000 + 32'(k), c == 0, 5'd9, 32'h22);
         if (!m_last_hold) k++;
      end
      check_val("starve_hold_cycles", 64'(dut_holds), 64'd1);
      idle();

      // Full FIFO with wrap-around: third result waits for ready
      s = 0;
      for (int c = 0; c < 16; c++) begin
         mv = (s < 3);
         cycle(0, c < 8, 5'(20 + (c % 4)), 32'hB000_0000 + 32'(c),
               mv, mv ? fr[s % 3] : 5'd0, mv ? fd[s % 3] : 32'd0);
         if (mv && m_last_push) s++;
      end

      // Side-unit write to r0: accepted, never buffered or written
      cycle(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h33);
      check_val("r0_count", 64'(fifo_count), 64'd0);
      idle();
      idle();

      // Reset mid-traffic with two buffered entries
      cycle(0, 1, 5'd12, 32'hC000_0001, 1, 5'd14, 32'h55);
      cycle(0, 1, 5'd13, 32'hC000_0002, 1, 5'd15, 32'h66);
      check_val("pre_reset_count", 64'(fifo_count), 64'd2);
      cycle(1, 1, 5'd12, 32'hC000_0003, 1, 5'd16, 32'h77);
      cycle(1, 1, 5'd12, 32'hC000_0003, 1, 5'd16, 32'h77);
      check_val("post_reset_wregno", 64'(rf_wregno), 64'd0);
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
